// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: timed A/B phase sequencer with min/max green, fixed yellow and a latched pedestrian request.
// Optional all-red clearance phases (A_CLR/B_CLR) are compiled in when TRAFFIC_ALLRED_EN is defined.
module traffic_phase_scheduler #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 10,
  parameter int YELLOW_CYC = 2
`ifdef TRAFFIC_ALLRED_EN
  ,
  parameter int ALLRED_CYC = 1
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [1:0] L_GREEN  = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_RED    = 2'b10;

  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_CYC - 1);
`ifdef TRAFFIC_ALLRED_EN
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(ALLRED_CYC - 1);
`endif

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    B_GRN = 3'd2,
    B_YEL = 3'd3
`ifdef TRAFFIC_ALLRED_EN
    ,
    A_CLR = 3'd4,
    B_CLR = 3'd5
`endif
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ped_pend;
  logic             r_walk;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_ped_pend_next;
  logic             w_walk_next;
  logic             w_min_met;
  logic             w_max_hit;
  logic             w_entering_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= A_GRN;
      r_cnt      <= '0;
      r_ped_pend <= 1'b0;
      r_walk     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_ped_pend <= w_ped_pend_next;
      r_walk     <= w_walk_next;
    end
  end

  // Sensors only pick the exit point inside the MIN_GREEN..MAX_GREEN window.
  always_comb begin
    w_min_met    = (r_cnt >= MIN_LAST);
    w_max_hit    = (r_cnt >= MAX_LAST);
    w_state_next = r_state;
    case (r_state)
      A_GRN: if (w_min_met && (!TA || r_ped_pend || ped_req || w_max_hit)) w_state_next = A_YEL;
`ifdef TRAFFIC_ALLRED_EN
      A_YEL: if (r_cnt == YEL_LAST) w_state_next = A_CLR;
      A_CLR: if (r_cnt == CLR_LAST) w_state_next = B_GRN;
      B_GRN: if (w_min_met && (!TB || w_max_hit)) w_state_next = B_YEL;
      B_YEL: if (r_cnt == YEL_LAST) w_state_next = B_CLR;
      B_CLR: if (r_cnt == CLR_LAST) w_state_next = A_GRN;
`else
      A_YEL: if (r_cnt == YEL_LAST) w_state_next = B_GRN;
      B_GRN: if (w_min_met && (!TB || w_max_hit)) w_state_next = B_YEL;
      B_YEL: if (r_cnt == YEL_LAST) w_state_next = A_GRN;
`endif
      default: w_state_next = A_GRN;
    endcase
  end

  // A request arriving on the very edge that enters B_GRN is served immediately rather than latched.
  always_comb begin
    w_entering_b    = (w_state_next == B_GRN) && (r_state != B_GRN);
    w_cnt_next      = (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
    w_ped_pend_next = r_ped_pend;
    if (w_entering_b) begin
      w_ped_pend_next = 1'b0;
    end else if (ped_req && (r_state != B_GRN)) begin
      w_ped_pend_next = 1'b1;
    end
    w_walk_next = 1'b0;
    if (w_state_next == B_GRN) begin
      w_walk_next = w_entering_b ? (r_ped_pend | ped_req) : r_walk;
    end
  end

  always_comb begin
    LA = L_RED;
    LB = L_RED;
    case (r_state)
      A_GRN:   LA = L_GREEN;
      A_YEL:   LA = L_YELLOW;
      B_GRN:   LB = L_GREEN;
      B_YEL:   LB = L_YELLOW;
      default: ;
    endcase
  end

  assign walk  = r_walk;
  assign phase = r_state;

  a_no_dual_green: assert property (@(posedge clk) disable iff (reset)
    !((LA == L_GREEN) && (LB == L_GREEN)));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: stimulus pushes per-cycle expected phase/walk, a negedge monitor compares.
// Build with TRAFFIC_ALLRED_EN defined to exercise the all-red clearance sequence instead of the default scenarios.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       TA = 1'b0;
  logic       TB = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] LA;
  logic [1:0] LB;
  logic       walk;
  logic [2:0] phase;

  traffic_phase_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .TA      (TA),
    .TB      (TB),
    .ped_req (ped_req),
    .LA      (LA),
    .LB      (LB),
    .walk    (walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ph;
    logic       wk;
    string      tag;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  function automatic logic [1:0] lamp_a(input logic [2:0] p);
    case (p)
      3'd0:    return 2'b00;
      3'd1:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] lamp_b(input logic [2:0] p);
    case (p)
      3'd2:    return 2'b00;
      3'd3:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // Monitor: one comparison per expected entry, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({phase, LA, LB, walk} !== {mon_e.ph, lamp_a(mon_e.ph), lamp_b(mon_e.ph), mon_e.wk}) begin
        failures++;
        $display("FAIL %s[%0d] got phase=%0d LA=%b LB=%b walk=%b, want phase=%0d LA=%b LB=%b walk=%b",
                 mon_e.tag, mon_e.idx, phase, LA, LB, walk,
                 mon_e.ph, lamp_a(mon_e.ph), lamp_b(mon_e.ph), mon_e.wk);
      end else begin
        $display("ok   %s[%0d] phase=%0d LA=%b LB=%b walk=%b", mon_e.tag, mon_e.idx, phase, LA, LB, walk);
      end
    end
  end

  task automatic push_exp(input string tag, input int idx, input logic [2:0] ph, input logic wk);
    exp_t e;
    e.ph  = ph;
    e.wk  = wk;
    e.tag = tag;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  function automatic byte chr(input string s, input int i);
    return (s.len() == 1) ? s[0] : s[i];
  endfunction

  // Called at posedge+1; one step per cycle. A single-character string means "constant for all steps".
  task automatic run_seq(input string tag, input string ta, input string tb, input string ped,
                         input string ph, input string wk);
    for (int i = 0; i < ph.len(); i++) begin
      TA      = (chr(ta, i) == "1");
      TB      = (chr(tb, i) == "1");
      ped_req = (chr(ped, i) == "1");
      push_exp(tag, i, 3'(int'(chr(ph, i)) - 48), chr(wk, i) == "1");
      @(posedge clk);
      #1;
    end
    TA      = 1'b0;
    TB      = 1'b0;
    ped_req = 1'b0;
  endtask

  // Reset asserted between edges; the monitor samples before the next edge, so a synchronous reset would show.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    push_exp(tag, 0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset("rst_init");
`ifdef TRAFFIC_ALLRED_EN
    run_seq("allred", "0", "0", "0", "0000114222233500001142222335", "0");
`else
    run_seq("idle", "0", "0", "0", "000011222233000011222233", "0");
    do_reset("rst_a");
    run_seq("max", "1", "1", "0", "0000000000112222222222330", "0");
    do_reset("rst_b");
    run_seq("ped_a", "1", "0", "010000010000000000000000000000",
            "000011222233000000000011222233", "000000111100000000000000000000");
    do_reset("rst_c");
    run_seq("ped_edge", "0000000000001111111111111111", "0", "0000010000000000000000000000",
            "0000112222330000000000112222", "0000001111000000000000000000");
    do_reset("rst_d");
    run_seq("pre_bgrn", "0", "0", "0100000", "0000112", "0000001");
    do_reset("rst_mid_bgrn");
    run_seq("post_bgrn", "1", "0", "0", "000000000011", "0");
    do_reset("rst_e");
    run_seq("pend_pre", "1", "0", "10", "00", "0");
    do_reset("rst_pend");
    run_seq("pend_drop", "1", "0", "0", "000000000011", "0");
`endif
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got pending=%0d, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
